four_bit_subtractor: RTL and testbench
======================================

Name: four_bit_subtractor

Overview:
- Registered 4-bit unsigned subtractor.
- Computes A − B by two's-complement addition, i.e. A + ~B + 1, using a ripple-carry full-adder chain.
- Delivers a 5-bit signed difference one clock later.
- Leaf arithmetic block used by datapath logic that needs a sign-correct difference of two nibbles.

Parameters:
- None. Operand width is fixed at 4. The shared package constant sets it; it is not overridden per instance.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- A  input  4  minuend, unsigned 0..15
- B  input  4  subtrahend, unsigned 0..15
- result  output  5  registered signed two's-complement difference A − B, range −15..+15

Behaviour:
- Clocking/reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset:
  - While rst_n = 0, result = 5'b00000 immediately, without waiting for a clock edge.
  - Deassertion is sampled on the next rising clk edge.
- Arithmetic:
  - Zero-extend A and B to 5 bits.
  - Form A_ext + (~B_ext) + 1 through a 5-stage ripple chain, with carry-in = 1 at bit 0.
  - Discard the final carry-out.
  - The 5-bit sum is the exact signed difference. Overflow is impossible over the full input range.
- Sign and borrow:
  - result[4] = 1 exactly when A < B (negative result, borrow).
  - result[4] = 0 when A ≥ B.
  - No separate borrow or carry port is provided.
- Latency:
  - result is registered. The difference of A/B sampled at rising edge N appears after edge N and holds until edge N+1.
  - No combinational path exists from A/B to result.
- Throughput: a new operand pair is accepted every cycle. There is no handshake and no valid signal. The output register updates on every edge while out of reset.
- Boundary cases:
  - A = B gives 00000.
  - A = 15, B = 0 gives 01111 (+15).
  - A = 0, B = 15 gives 10001 (−15).
  - X/Z on inputs need not be handled.
- Reset mid-operation:
  - Asserting rst_n clears result asynchronously and discards any in-flight value.
  - The first edge after release registers the then-present A − B.

Decomposition:
- Shared package holds:
  - OPERAND_W = 4
  - RESULT_W = OPERAND_W + 1
  - typedef operand_t: logic [OPERAND_W−1:0]
  - typedef result_t: logic [RESULT_W−1:0]
- One sub-module, full_adder (a, b, cin → sum, cout), instantiated RESULT_W times in a generate ripple chain. B-inversion and carry-in = 1 live in the parent.
- Output register is in the parent.

Test Plan:
- Reset: hold rst_n = 0 with A = 5, B = 3 across several edges → result = 00000 throughout. Release rst_n → 00010 after the next edge.
- Non-negative differences, checked one cycle after apply:
  - A = 1, B = 0 → 00001
  - A = 2, B = 1 → 00001
  - A = 3, B = 2 → 00001
  - A = 15, B = 8 → 00111
- Zero: A = B for 0, 2 and 3 → 00000.
- Negative differences:
  - A = 1, B = 9 → 11000 (−8)
  - A = 4, B = 12 → 11000
  - A = 9, B = 12 → 11101 (−3)
- Extremes: A = 15, B = 0 → 01111. A = 0, B = 15 → 10001. Exhaustive sweep of all 256 pairs compared against the golden value (A − B) mod 32.
- Async reset mid-stream: apply back-to-back pairs every cycle and pulse rst_n low between edges → result drops to 00000 before the next edge. After release, results resume with 1-cycle latency and no stale value.

Source files
------------

// File: rtl/four_bit_subtractor_pkg.sv
// Shared widths and types for the registered nibble subtractor.
// Operand width is fixed here and is not overridden per instance.
package four_bit_subtractor_pkg;

    localparam int OPERAND_W = 4;
    localparam int RESULT_W  = OPERAND_W + 1;

    typedef logic [OPERAND_W-1:0] operand_t;
    typedef logic [RESULT_W-1:0]  result_t;

endpackage : four_bit_subtractor_pkg

// File: rtl/four_bit_subtractor_full_adder.sv
// Single-bit full adder: the stage cell of the subtractor's ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/four_bit_subtractor.sv
// Registered 4-bit unsigned subtractor: result = A - B as a 5-bit signed value,
// formed as A + ~B + 1 through a ripple-carry chain and registered once.
module four_bit_subtractor
    import four_bit_subtractor_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OPERAND_W-1:0] A,
    input  logic [OPERAND_W-1:0] B,
    output logic [RESULT_W-1:0]  result
);

    result_t a_ext;
    result_t b_inv;
    result_t sum;
    result_t carry;
    logic    cout_unused;

    // Zero-extend both operands so the fifth bit carries the sign of the difference.
    assign a_ext    = {1'b0, A};
    assign b_inv    = ~{1'b0, B};
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < RESULT_W; i++) begin : g_ripple
        if (i < RESULT_W - 1) begin : g_mid
            full_adder u_fa (
                .a    (a_ext[i]),
                .b    (b_inv[i]),
                .cin  (carry[i]),
                .sum  (sum[i]),
                .cout (carry[i+1])
            );
        end else begin : g_last
            // Final carry-out is discarded: the 5-bit sum is already the exact difference.
            full_adder u_fa (
                .a    (a_ext[i]),
                .b    (b_inv[i]),
                .cin  (carry[i]),
                .sum  (sum[i]),
                .cout (cout_unused)
            );
        end
    end

    // NOTE: registered state uses non-blocking assignment; the reset branch is
    // in the sensitivity list so result clears without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
        end else begin
            result <= sum;
        end
    end

endmodule : four_bit_subtractor

// File: tb/tb_four_bit_subtractor.sv
// Self-checking bench for four_bit_subtractor: directed vectors with literal
// expectations plus an arithmetic reference model compared every cycle.
module tb_four_bit_subtractor;
    import four_bit_subtractor_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n;
    operand_t A;
    operand_t B;
    result_t  result;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_on = 1'b0;
    result_t model;

    always #5 clk = ~clk;

    four_bit_subtractor dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .result (result)
    );

    task automatic check(input string name, input result_t act, input result_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer subtraction taken modulo 32, cleared by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model = '0;
        else        model = result_t'(int'(A) - int'(B));
    end

    always @(negedge clk) begin
        if (model_on) check("model", result, model);
    end

    task automatic apply(input int a, input int b, input result_t exp, input string name);
        @(negedge clk);
        A = operand_t'(a);
        B = operand_t'(b);
        @(posedge clk);
        #1;
        check(name, result, exp);
    endtask

    typedef struct {
        int      a;
        int      b;
        result_t exp;
    } vec_t;

    vec_t vecs[13] = '{
        '{1, 0, 5'b00001}, '{2, 1, 5'b00001}, '{3, 2, 5'b00001}, '{15, 8, 5'b00111},
        '{0, 0, 5'b00000}, '{2, 2, 5'b00000}, '{3, 3, 5'b00000},
        '{1, 9, 5'b11000}, '{4, 12, 5'b11000}, '{9, 12, 5'b11101},
        '{15, 0, 5'b01111}, '{0, 15, 5'b10001}, '{9, 1, 5'b01000}
    };

    initial begin
        rst_n = 1'b1;
        A     = 4'd5;
        B     = 4'd3;
        #2;
        rst_n = 1'b0;
        #1;
        model_on = 1'b1;
        check("reset_async", result, 5'b00000);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_hold", result, 5'b00000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", result, 5'b00010);

        foreach (vecs[i]) apply(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec_%0d", i));

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                @(negedge clk);
                A = operand_t'(a);
                B = operand_t'(b);
            end
        end

        // In-flight pair is discarded by a reset pulse between edges.
        apply(9, 1, 5'b01000, "pre_reset");
        @(negedge clk);
        A = 4'd6;
        B = 4'd1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset", result, 5'b00000);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_reset", result, 5'b00101);
        apply(2, 7, 5'b11011, "after_reset_next");

        @(negedge clk);
        model_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_four_bit_subtractor
